// File: rtl/alu_md_sequencer.sv
// alu_md_sequencer
//
// ALU control decoder with an optional multi-cycle multiply/divide sequencer
// for the RISC-V M extension.
//
// The M-extension sequencer is built only when the macro MD_EXT_EN is defined.
// Without it, the block is a purely combinational ALU decoder and all
// mul/div outputs are tied low.
//
// Ports:
//   clk        in   sole clock, rising edge
//   reset      in   asynchronous, active-high reset
//   opb5       in   opcode bit 5
//   funct3     in   instruction funct3 field
//   funct7b5   in   funct7 bit 5
//   funct7b0   in   funct7 bit 0 (M-extension marker)
//   ALUOp      in   main-decoder ALU operation class
//   valid_in   in   instruction fields and operands are valid
//   flush      in   synchronous abort of any in-flight mul/div
//   srcA/srcB  in   XLEN-bit operands for mul/div
//   ALUControl out  combinational ALU select
//   md_busy    out  sequencer iterating (MUL or DIV)
//   md_done    out  one-cycle completion pulse
//   stall      out  hold the pipeline until the mul/div result is ready
//   md_result  out  mul/div result, valid while md_done is high
module alu_md_sequencer #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            opb5,
    input  logic [2:0]      funct3,
    input  logic            funct7b5,
    input  logic            funct7b0,
    input  logic [1:0]      ALUOp,
    input  logic            valid_in,
    input  logic            flush,
    input  logic [XLEN-1:0] srcA,
    input  logic [XLEN-1:0] srcB,
    output logic [3:0]      ALUControl,
    output logic            md_busy,
    output logic            md_done,
    output logic            stall,
    output logic [XLEN-1:0] md_result
);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    logic is_md;

`ifdef MD_EXT_EN
    assign is_md = (ALUOp == 2'b10) & opb5 & funct7b0;
`else
    assign is_md = 1'b0;
`endif

    // M-extension instructions use the adder slot so the ALU stays quiet.
    always_comb begin
        ALUControl = ALU_ADD;
        if (is_md) begin
            ALUControl = ALU_ADD;
        end else begin
            case (ALUOp)
                2'b00: ALUControl = ALU_ADD;
                2'b01: ALUControl = ALU_SUB;
                default: begin
                    case (funct3)
                        3'b000:  ALUControl = (funct7b5 & opb5) ? ALU_SUB : ALU_ADD;
                        3'b001:  ALUControl = ALU_SLL;
                        3'b010:  ALUControl = ALU_SLT;
                        3'b011:  ALUControl = ALU_SLTU;
                        3'b100:  ALUControl = ALU_XOR;
                        3'b101:  ALUControl = funct7b5 ? ALU_SRA : ALU_SRL;
                        3'b110:  ALUControl = ALU_OR;
                        default: ALUControl = ALU_AND;
                    endcase
                end
            endcase
        end
    end

`ifdef MD_EXT_EN
    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] MUL  = 2'b01;
    localparam logic [1:0] DIV  = 2'b10;
    localparam logic [1:0] DONE = 2'b11;
    localparam int CW = $clog2(XLEN);

    logic [1:0]      state;
    logic [CW-1:0]   count;
    logic [XLEN-1:0] acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] operand_b;
    logic [2:0]      op;
    logic            neg_res;

    // Both algorithms work on magnitudes; the sign is reapplied at the end.
    // For the div/rem group funct3[0] marks the unsigned forms.
    logic            signed_a, signed_b, neg_a, neg_b;
    logic [XLEN-1:0] abs_a, abs_b, special_result;
    logic            div_zero, div_ovf;

    assign signed_a = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    assign signed_b = funct3[2] ? ~funct3[0] : ~funct3[1];
    assign neg_a    = signed_a & srcA[XLEN-1];
    assign neg_b    = signed_b & srcB[XLEN-1];
    assign abs_a    = neg_a ? -srcA : srcA;
    assign abs_b    = neg_b ? -srcB : srcB;
    assign div_zero = (srcB == '0);
    assign div_ovf  = signed_a & (srcA == {1'b1, {(XLEN-1){1'b0}}}) & (srcB == {XLEN{1'b1}});

    // Early-out values: funct3[1] selects the remainder forms.
    always_comb begin
        special_result = '0;
        if (div_zero)
            special_result = funct3[1] ? srcA : {XLEN{1'b1}};
        else
            special_result = funct3[1] ? '0 : srcA;
    end

    // One shift-add multiply step: acc_lo holds the remaining multiplier bits
    // and collects the low product half as the partial sum shifts right.
    logic [XLEN:0]   mul_sum;
    // One restoring-division step: acc_hi is the partial remainder and
    // acc_lo shifts out dividend bits while shifting in quotient bits.
    logic [XLEN:0]   div_shift;
    logic [XLEN-1:0] div_diff;
    logic            div_ge;
    logic [XLEN-1:0] step_hi, step_lo;

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand_b} : '0);
    assign div_shift = {acc_hi, acc_lo[XLEN-1]};
    assign div_ge    = (div_shift >= {1'b0, operand_b});
    assign div_diff  = div_shift[XLEN-1:0] - operand_b;
    assign step_hi   = (state == MUL) ? mul_sum[XLEN:1]
                                      : (div_ge ? div_diff : div_shift[XLEN-1:0]);
    assign step_lo   = (state == MUL) ? {mul_sum[0], acc_lo[XLEN-1:1]}
                                      : {acc_lo[XLEN-2:0], div_ge};

    // Result formed from the last step's outputs so it can be registered
    // on the edge that enters DONE.
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   final_result;

    assign prod   = {step_hi, step_lo};
    assign prod_s = neg_res ? -prod : prod;

    always_comb begin
        final_result = '0;
        case (op)
            3'b000:          final_result = prod_s[XLEN-1:0];
            3'b100, 3'b101:  final_result = neg_res ? -step_lo : step_lo;
            3'b110, 3'b111:  final_result = neg_res ? -step_hi : step_hi;
            default:         final_result = prod_s[2*XLEN-1:XLEN];
        endcase
    end

    // Sequencer: flush wins over everything, divide-by-zero and signed
    // overflow bypass the iteration and go straight to DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            operand_b <= '0;
            op        <= '0;
            neg_res   <= 1'b0;
            md_result <= '0;
        end else if (flush) begin
            state <= IDLE;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_in & is_md) begin
                        op    <= funct3;
                        count <= '0;
                        if (funct3[2] & (div_zero | div_ovf)) begin
                            md_result <= special_result;
                            state     <= DONE;
                        end else begin
                            acc_hi    <= '0;
                            acc_lo    <= abs_a;
                            operand_b <= abs_b;
                            neg_res   <= (funct3[2] & funct3[1]) ? neg_a : (neg_a ^ neg_b);
                            state     <= funct3[2] ? DIV : MUL;
                        end
                    end
                end
                MUL, DIV: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    count  <= count + 1'b1;
                    if (count == CW'(XLEN-1)) begin
                        md_result <= final_result;
                        count     <= '0;
                        state     <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign md_done = (state == DONE);
    assign md_busy = (state == MUL) | (state == DIV);
    assign stall   = valid_in & is_md & ~md_done;
`else
    logic unused_inputs;
    assign unused_inputs = ^{clk, reset, funct7b0, valid_in, flush, srcA, srcB};

    assign md_busy   = 1'b0;
    assign md_done   = 1'b0;
    assign stall     = 1'b0;
    assign md_result = '0;
`endif

endmodule

// File: tb/tb_alu_md_sequencer.sv
// tb_alu_md_sequencer
//
// Scoreboard bench for alu_md_sequencer. Stimulus tasks push expected
// ALUControl values and expected mul/div results; independent monitor
// processes pop and compare when the DUT presents a result.
module tb_alu_md_sequencer;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic            opb5, funct7b5, funct7b0, valid_in, flush;
    logic [2:0]      funct3;
    logic [1:0]      ALUOp;
    logic [XLEN-1:0] srcA, srcB;
    logic [3:0]      ALUControl;
    logic            md_busy, md_done, stall;
    logic [XLEN-1:0] md_result;

    alu_md_sequencer #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .opb5(opb5), .funct3(funct3),
        .funct7b5(funct7b5), .funct7b0(funct7b0), .ALUOp(ALUOp),
        .valid_in(valid_in), .flush(flush), .srcA(srcA), .srcB(srcB),
        .ALUControl(ALUControl), .md_busy(md_busy), .md_done(md_done),
        .stall(stall), .md_result(md_result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [XLEN-1:0] result;
        int              acc_cyc;
        int              cycles;
        int              tag;
    } md_exp_t;

    md_exp_t    md_q[$];
    logic [3:0] dec_q[$];
    event       dec_ev;
    int         stall_run = 0;
    int         md_tag = 0;
    int         dec_n = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Decode monitor: compares ALUControl whenever a decode vector settles.
    initial begin
        logic [3:0] exp_ctl;
        forever begin
            @(dec_ev);
            if (dec_q.size() > 0) begin
                exp_ctl = dec_q.pop_front();
                checkOutput($sformatf("alucontrol%0d", dec_n), {60'b0, ALUControl}, {60'b0, exp_ctl});
                dec_n++;
            end
        end
    end

    // Mul/div monitor: counts consecutive stall cycles and checks result,
    // latency and stall length on every md_done pulse.
    initial begin
        md_exp_t e;
        forever begin
            @(negedge clk);
            if (md_done) begin
                if (md_q.size() == 0) begin
                    checkOutput("md_done_spurious", {63'b0, md_done}, 64'd0);
                end else begin
                    e = md_q.pop_front();
                    checkOutput($sformatf("md%0d_result", e.tag), {32'b0, md_result}, {32'b0, e.result});
                    checkOutput($sformatf("md%0d_latency", e.tag), 64'(cyc - e.acc_cyc + 1), 64'(e.cycles));
                    checkOutput($sformatf("md%0d_stall", e.tag), 64'(stall_run), 64'(e.cycles));
                end
                stall_run = 0;
            end else if (stall) begin
                stall_run++;
            end else begin
                stall_run = 0;
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] op, input logic [2:0] f3, input logic f7b5,
                                 input logic ob5, input logic f7b0, input logic [3:0] exp_ctl);
        ALUOp    = op;
        funct3   = f3;
        funct7b5 = f7b5;
        opb5     = ob5;
        funct7b0 = f7b0;
        #1;
        dec_q.push_back(exp_ctl);
        -> dec_ev;
        #1;
    endtask

    task automatic setMdFields(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        ALUOp    = 2'b10;
        opb5     = 1'b1;
        funct7b5 = 1'b0;
        funct7b0 = 1'b1;
        funct3   = f3;
        srcA     = a;
        srcB     = b;
    endtask

    // Issues one mul/div, holds valid_in like a stalled pipeline until
    // md_done, and scrambles operands while the operation is in flight.
    task automatic applyMdStimulus(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                   input logic [XLEN-1:0] exp_res, input int cycles);
        md_exp_t e;
        logic    seen;
        int      n;
        @(posedge clk);
        #1;
        setMdFields(f3, a, b);
        valid_in  = 1'b1;
        e.result  = exp_res;
        e.acc_cyc = cyc + 1;
        e.cycles  = cycles;
        e.tag     = md_tag;
        md_tag++;
        md_q.push_back(e);
        seen = 1'b0;
        n    = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            if (md_done) begin
                seen = 1'b1;
            end else begin
                @(posedge clk);
                #1;
                srcA = ~a;
                srcB = a ^ b ^ 32'h5A5A_5A5A;
            end
            n++;
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        if (!seen) begin
            checkOutput($sformatf("md%0d_timeout", e.tag), {63'b0, seen}, 64'd1);
            md_q.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        flush    = 1'b0;
        valid_in = 1'b0;
        ALUOp    = 2'b00;
        funct3   = 3'b000;
        funct7b5 = 1'b0;
        funct7b0 = 1'b0;
        opb5     = 1'b0;
        srcA     = '0;
        srcB     = '0;
        #1;
        checkOutput("reset_busy", {63'b0, md_busy}, 64'd0);
        checkOutput("reset_done", {63'b0, md_done}, 64'd0);
        checkOutput("reset_result", {32'b0, md_result}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        $display("[TB] decode vectors");
        applyStimulus(2'b00, 3'b111, 1'b1, 1'b1, 1'b0, 4'b0000);
        applyStimulus(2'b01, 3'b010, 1'b0, 1'b1, 1'b0, 4'b0001);
        applyStimulus(2'b10, 3'b000, 1'b1, 1'b1, 1'b0, 4'b0001);
        applyStimulus(2'b10, 3'b000, 1'b1, 1'b0, 1'b0, 4'b0000);
        applyStimulus(2'b10, 3'b000, 1'b0, 1'b1, 1'b0, 4'b0000);
        applyStimulus(2'b10, 3'b001, 1'b0, 1'b1, 1'b0, 4'b0101);
        applyStimulus(2'b10, 3'b010, 1'b0, 1'b1, 1'b0, 4'b1000);
        applyStimulus(2'b10, 3'b011, 1'b0, 1'b1, 1'b0, 4'b1001);
        applyStimulus(2'b10, 3'b100, 1'b0, 1'b1, 1'b0, 4'b0100);
        applyStimulus(2'b10, 3'b101, 1'b0, 1'b1, 1'b0, 4'b0110);
        applyStimulus(2'b10, 3'b101, 1'b1, 1'b1, 1'b0, 4'b0111);
        applyStimulus(2'b10, 3'b110, 1'b0, 1'b1, 1'b0, 4'b0011);
        applyStimulus(2'b10, 3'b111, 1'b0, 1'b1, 1'b0, 4'b0010);
        applyStimulus(2'b11, 3'b111, 1'b0, 1'b0, 1'b0, 4'b0010);
        applyStimulus(2'b10, 3'b000, 1'b1, 1'b0, 1'b1, 4'b0000);
`ifdef MD_EXT_EN
        applyStimulus(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 4'b0000);
`else
        applyStimulus(2'b10, 3'b100, 1'b0, 1'b1, 1'b1, 4'b0100);
`endif

`ifdef MD_EXT_EN
        $display("[TB] mul/div vectors");
        applyMdStimulus(3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, XLEN + 1);
        applyMdStimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, XLEN + 1);
        applyMdStimulus(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, XLEN + 1);
        applyMdStimulus(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, XLEN + 1);
        applyMdStimulus(3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, XLEN + 1);
        applyMdStimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        applyMdStimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        applyMdStimulus(3'b111, 32'd5,         32'd0,         32'd5,         1);
        applyMdStimulus(3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        applyMdStimulus(3'b100, 32'd5,         32'd0,         32'hFFFF_FFFF, 1);
        applyMdStimulus(3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, XLEN + 1);
        applyMdStimulus(3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, XLEN + 1);
        applyMdStimulus(3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, XLEN + 1);
        applyMdStimulus(3'b110, 32'd7,         32'hFFFF_FFFE, 32'd1,         XLEN + 1);
        applyMdStimulus(3'b101, 32'd100,       32'd7,         32'd14,        XLEN + 1);
        applyMdStimulus(3'b111, 32'd100,       32'd7,         32'd2,         XLEN + 1);

        $display("[TB] flush blocks acceptance");
        @(posedge clk);
        #1;
        setMdFields(3'b000, 32'd3, 32'd5);
        valid_in = 1'b1;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("flush_blocks_accept", {63'b0, md_busy}, 64'd0);
        valid_in = 1'b0;
        flush    = 1'b0;

        $display("[TB] reset during div");
        @(posedge clk);
        #1;
        setMdFields(3'b100, 32'd1000, 32'd3);
        valid_in = 1'b1;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("busy_before_reset", {63'b0, md_busy}, 64'd1);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("reset_mid_busy", {63'b0, md_busy}, 64'd0);
        checkOutput("reset_mid_done", {63'b0, md_done}, 64'd0);
        checkOutput("reset_mid_result", {32'b0, md_result}, 64'd0);
        @(negedge clk);
        valid_in = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        checkOutput("idle_after_reset", {63'b0, md_busy}, 64'd0);
        applyMdStimulus(3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, XLEN + 1);

        $display("[TB] flush during mul");
        @(posedge clk);
        #1;
        setMdFields(3'b000, 32'd3, 32'd5);
        valid_in = 1'b1;
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("busy_before_flush", {63'b0, md_busy}, 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        checkOutput("flush_busy", {63'b0, md_busy}, 64'd0);
        checkOutput("flush_done", {63'b0, md_done}, 64'd0);
        repeat (40) @(posedge clk);
        applyMdStimulus(3'b000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, XLEN + 1);
`else
        $display("[TB] mul/div outputs tied off");
        @(posedge clk);
        #1;
        setMdFields(3'b000, 32'd7, 32'd3);
        valid_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("tied_busy", {63'b0, md_busy}, 64'd0);
        checkOutput("tied_done", {63'b0, md_done}, 64'd0);
        checkOutput("tied_stall", {63'b0, stall}, 64'd0);
        checkOutput("tied_result", {32'b0, md_result}, 64'd0);
        valid_in = 1'b0;
`endif

        repeat (5) @(posedge clk);
        #1;
        checkOutput("md_queue_drained", 64'(md_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_md_sequencer.md
ALU_MD_SEQUENCER -- requirements
Module: alu_md_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (legal values 8..64, even).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports opb5 (1), funct3 (3), funct7b5 (1), funct7b0 (1) and ALUOp (2) as inputs carrying instruction decode fields.
REQ-005 SHALL have port valid_in  input  1  current instruction fields and operands are valid.
REQ-006 SHALL have port flush  input  1  synchronous abort of any in-flight mul/div.
REQ-007 SHALL have ports srcA, srcB  input  XLEN  operands for mul/div.
REQ-008 SHALL have port ALUControl  output  4  combinational ALU select.
REQ-009 SHALL have ports md_busy (1), md_done (1) and stall (1) as outputs giving mul/div status.
REQ-010 SHALL have port md_result  output  XLEN  mul/div result, valid while md_done=1.

Function
REQ-011 ALUControl encoding SHALL be: add 0000, sub 0001, and 0010, or 0011, xor 0100, sll 0101, srl 0110, sra 0111, slt 1000, sltu 1001.
REQ-012 ALUOp=00 SHALL give add; ALUOp=01 SHALL give sub; otherwise decode funct3: 000 sub if funct7b5&opb5 else add; 001 sll; 010 slt; 011 sltu; 100 xor; 101 sra if funct7b5 else srl; 110 or; 111 and.
REQ-013 is_md SHALL be ALUOp=10 & opb5 & funct7b0; funct3 then selects mul, mulh, mulhsu, mulhu, div, divu, rem, remu (000..111); ALUControl SHALL be 0000 when is_md.
REQ-014 FSM states SHALL be IDLE, MUL, DIV, DONE.
REQ-015 IDLE->MUL (funct3[2]=0) or IDLE->DIV (funct3[2]=1) SHALL occur on the edge where valid_in & is_md & ~flush; operands and funct3 are captured at that edge.
REQ-016 MUL and DIV SHALL each run exactly XLEN iterations, counted by an internal counter, then go to DONE.
REQ-017 DONE SHALL last exactly one cycle with md_done=1 and md_result valid, then return to IDLE.
REQ-018 Normal latency SHALL be md_done high in cycle XLEN+1 after the accepting edge.
REQ-019 md_busy SHALL be 1 in MUL and DIV, else 0.
REQ-020 stall SHALL be valid_in & is_md & ~md_done (combinational).
REQ-021 Multiply results SHALL be the low XLEN bits (mul) or high XLEN bits (mulh/mulhsu/mulhu) of the 2*XLEN product, with signedness per RV32M.
REQ-022 div/rem SHALL truncate toward zero; rem takes the sign of the dividend.
REQ-023 Divide by zero SHALL skip DIV and go IDLE->DONE directly; quotient is all ones and remainder is srcA.
REQ-024 Signed overflow (srcA = most negative, srcB = -1, div/rem) SHALL skip DIV and go to DONE directly; quotient is srcA and remainder is 0.
REQ-025 flush in MUL, DIV or DONE SHALL force IDLE at the next edge, with md_done not asserted afterwards; flush has priority over acceptance.
REQ-026 Changes to inputs while md_busy=1 SHALL NOT affect the in-flight operation.

Reset
REQ-027 reset SHALL immediately force state IDLE, counter 0, md_result 0, md_busy 0 and md_done 0, including when asserted mid-operation.
REQ-028 After reset deasserts, the first accept SHALL behave exactly as after power-up.

Configuration
REQ-029 Macro MD_EXT_EN defined: M-extension decode and the sequencer SHALL be present as above.
REQ-030 MD_EXT_EN undefined: funct7b0 SHALL be ignored, is_md=0, decode per REQ-012 only; md_busy, md_done and stall tied 0; md_result tied 0; no sequential logic.

Verification
REQ-031 XLEN=32, ALUOp=10, funct3=000, funct7b5=1, opb5=1 -> ALUControl=0001; with opb5=0 -> 0000.
REQ-032 mul, srcA=7, srcB=-3 -> stall high 33 cycles, md_done pulses one cycle 33 cycles after accept, md_result=0xFFFFFFEB.
REQ-033 mulhu, 0xFFFFFFFF x 0xFFFFFFFF -> md_result=0xFFFFFFFE; mulh of the same operands -> 0x00000000.
REQ-034 div 0x80000000 / 0xFFFFFFFF -> md_done 1 cycle after accept, md_result=0x80000000; remu 5 / 0 -> md_result=5 after 1 cycle; divu 5 / 0 -> 0xFFFFFFFF.
REQ-035 rem -7 / 2 -> md_result=0xFFFFFFFF; div -7 / 2 -> 0xFFFFFFFD.
REQ-036 reset asserted at iteration 10 of a div -> md_busy=0 without waiting for a clock edge, md_done never asserts; flush at iteration 5 -> IDLE next edge, and a new mul then completes with correct result.
